ext_field_agent: RTL and testbench

//   Slave-side endpoint for one external register field exported by a RegSpaceBase register space.

---
 rtl/ext_field_pkg.sv | 24 ++
 rtl/ext_field_fifo.sv | 78 +++++++
 rtl/ext_field_agent.sv | 185 ++++++++++++++++++
 tb/tb_ext_field_agent.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_field_pkg.sv
// ---------------------------------------------------------------------------
// ext_field_pkg
//   Shared types and helpers for the external-field agent.
//   rd_state_e : read-path FSM states
//   RD_CNT_W   : width of the read-latency down-counter
//   ptr_w()    : FIFO pointer width (address bits plus one wrap bit)
// ---------------------------------------------------------------------------
package ext_field_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rd_state_e;

  localparam int RD_CNT_W = 4;

  // Extra MSB distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ext_field_fifo.sv
// ---------------------------------------------------------------------------
// ext_field_fifo
//   Synchronous write buffer between the register space and the hardware
//   consumer of an external field.
//   Parameters: WIDTH (entry width), DEPTH (entries, power of two, >=2)
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     i_push, i_wdat    enqueue request and data (ignored when full)
//     i_pop             dequeue request (ignored when empty)
//     o_full, o_empty   occupancy flags
//     o_head            oldest entry
//     o_newest, o_one   newest entry / exactly one entry held; present only
//                       when EXT_FIELD_RD_BYPASS_EN is defined
// ---------------------------------------------------------------------------
module ext_field_fifo
  import ext_field_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
`ifdef EXT_FIELD_RD_BYPASS_EN
  ,
  output logic [WIDTH-1:0] o_newest,
  output logic             o_one
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  // Full: wrap bits differ while the address bits coincide.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

`ifdef EXT_FIELD_RD_BYPASS_EN
  logic [PTR_W-1:0] w_count;
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign o_one    = (w_count == PTR_ONE);
  // Adding all-ones is a modulo decrement: slot written most recently.
  assign o_newest = r_mem[r_wr_ptr[AW-1:0] + {AW{1'b1}}];
`endif

  // Pointer update; wrap is implicit because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdat;
  end

endmodule

// File: rtl/ext_field_agent.sv
// ---------------------------------------------------------------------------
// ext_field_agent
//   Endpoint for one external register field. Software writes are buffered
//   and drained to hardware; the field register is updated by drained writes
//   and by direct hardware sets; reads return after RD_LAT extra cycles.
//   Optional feature macro: EXT_FIELD_RD_BYPASS_EN (reads skip draining and
//   return the newest buffered write when one is pending).
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     rvld / rrdy / rdat          read request, one-cycle response strobe, data
//     wvld / wdat / wrdy          write request, data, combinational accept
//     hw_wvld / hw_wdat / hw_wrdy buffered write towards hardware
//     hw_set_vld / hw_set_dat     direct hardware update of the field
//     field_val                   current field register
//     pending                     write buffer not empty
// ---------------------------------------------------------------------------
module ext_field_agent
  import ext_field_pkg::*;
#(
  parameter int          WIDTH   = 1,
  parameter int          DEPTH   = 4,
  parameter int          RD_LAT  = 2,
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rvld,
  output logic             rrdy,
  output logic [WIDTH-1:0] rdat,
  input  logic             wvld,
  input  logic [WIDTH-1:0] wdat,
  output logic             wrdy,
  output logic             hw_wvld,
  output logic [WIDTH-1:0] hw_wdat,
  input  logic             hw_wrdy,
  input  logic             hw_set_vld,
  input  logic [WIDTH-1:0] hw_set_dat,
  output logic [WIDTH-1:0] field_val,
  output logic             pending
);

  localparam logic [WIDTH-1:0]    RST_V    = RST_VAL[WIDTH-1:0];
  localparam logic [RD_CNT_W-1:0] LAT_INIT = RD_CNT_W'(RD_LAT);
  localparam logic [RD_CNT_W-1:0] CNT_ONE  = {{(RD_CNT_W-1){1'b0}}, 1'b1};

  rd_state_e             r_state;
  logic [RD_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]      r_field;
  logic [WIDTH-1:0]      r_rdat;
  logic                  r_rrdy;

  logic                  w_full;
  logic                  w_empty;
  logic [WIDTH-1:0]      w_head;
  logic                  w_push;
  logic                  w_pop;
  logic [WIDTH-1:0]      w_field_nxt;
  logic [WIDTH-1:0]      w_rd_src;

`ifdef EXT_FIELD_RD_BYPASS_EN
  logic [WIDTH-1:0]      w_newest;
  logic                  w_one;
`endif

  ext_field_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_wdat   (wdat),
    .i_pop    (w_pop),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head)
`ifdef EXT_FIELD_RD_BYPASS_EN
    ,
    .o_newest (w_newest),
    .o_one    (w_one)
`endif
  );

  // Writes are refused for the whole read so a drain cannot be starved.
  assign wrdy      = !w_full && (r_state == IDLE);
  assign w_push    = wvld && wrdy;
  assign w_pop     = !w_empty && hw_wrdy;
  assign hw_wvld   = !w_empty;
  assign hw_wdat   = w_head;
  assign pending   = !w_empty;
  assign field_val = r_field;
  assign rrdy      = r_rrdy;
  assign rdat      = r_rdat;

  // Next field value; a hardware set overrides a same-cycle drained write.
  always_comb begin
    w_field_nxt = r_field;
    if (hw_set_vld) begin
      w_field_nxt = hw_set_dat;
    end else if (w_pop) begin
      w_field_nxt = w_head;
    end else begin
      w_field_nxt = r_field;
    end
  end

  // Value captured into the read response register.
  always_comb begin
    w_rd_src = w_field_nxt;
`ifdef EXT_FIELD_RD_BYPASS_EN
    // Newest buffered write wins if anything remains after this cycle's pop.
    if (!w_empty && !(w_pop && w_one)) begin
      w_rd_src = w_newest;
    end else begin
      w_rd_src = w_field_nxt;
    end
`endif
  end

  // Architectural field register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_field <= RST_V;
    end else begin
      r_field <= w_field_nxt;
    end
  end

  // Read FSM with latency counter and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {RD_CNT_W{1'b0}};
      r_rrdy  <= 1'b0;
      r_rdat  <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_rrdy <= 1'b0;
          r_rdat <= {WIDTH{1'b0}};
          if (rvld) begin
`ifdef EXT_FIELD_RD_BYPASS_EN
            r_state <= WAIT;
            r_cnt   <= LAT_INIT;
`else
            // A write accepted alongside the read must land before the read.
            if (w_empty && !w_push) begin
              r_state <= WAIT;
              r_cnt   <= LAT_INIT;
            end else begin
              r_state <= DRAIN;
            end
`endif
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_state <= WAIT;
            r_cnt   <= LAT_INIT;
          end
        end
        WAIT: begin
          if (r_cnt == {RD_CNT_W{1'b0}}) begin
            r_state <= RESP;
            r_rrdy  <= 1'b1;
            r_rdat  <= w_rd_src;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_rrdy  <= 1'b0;
          r_rdat  <= {WIDTH{1'b0}};
        end
        default: begin
          r_state <= IDLE;
          r_rrdy  <= 1'b0;
          r_rdat  <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_field_agent.sv
// ---------------------------------------------------------------------------
// tb_ext_field_agent
//   Self-checking bench for ext_field_agent (WIDTH=3, DEPTH=4, RD_LAT=2,
//   RST_VAL=2): directed vector table, hand-written read/reset sequences and
//   a randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ext_field_agent;

  localparam int W      = 3;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam logic [W-1:0] RST_V = 3'd2;
`ifdef EXT_FIELD_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         rvld;
  logic         rrdy;
  logic [W-1:0] rdat;
  logic         wvld;
  logic [W-1:0] wdat;
  logic         wrdy;
  logic         hw_wvld;
  logic [W-1:0] hw_wdat;
  logic         hw_wrdy;
  logic         hw_set_vld;
  logic [W-1:0] hw_set_dat;
  logic [W-1:0] field_val;
  logic         pending;

  int n_chk = 0;
  int n_err = 0;

  ext_field_agent #(
    .WIDTH   (W),
    .DEPTH   (DEPTH),
    .RD_LAT  (RD_LAT),
    .RST_VAL (32'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rvld       (rvld),
    .rrdy       (rrdy),
    .rdat       (rdat),
    .wvld       (wvld),
    .wdat       (wdat),
    .wrdy       (wrdy),
    .hw_wvld    (hw_wvld),
    .hw_wdat    (hw_wdat),
    .hw_wrdy    (hw_wrdy),
    .hw_set_vld (hw_set_vld),
    .hw_set_dat (hw_set_dat),
    .field_val  (field_val),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; rvld = 1'b0; wvld = 1'b0; wdat = '0; hw_wrdy = 1'b0;
    hw_set_vld = 1'b0; hw_set_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic wv; logic [W-1:0] wd; logic hr; logic sv; logic [W-1:0] sd; logic rv;
    logic ewrdy; logic ehwv; logic [W-1:0] ehwd; logic [W-1:0] efv;
    logic epend; logic errdy; logic [W-1:0] erdat;
  } vec_t;

  function automatic vec_t mk(input int wv, wd, hr, sv, sd, rv,
                              ew, eh, ehd, ef, ep, er, erd);
    vec_t v;
    v.wv = 1'(wv); v.wd = 3'(wd); v.hr = 1'(hr); v.sv = 1'(sv); v.sd = 3'(sd);
    v.rv = 1'(rv); v.ewrdy = 1'(ew); v.ehwv = 1'(eh); v.ehwd = 3'(ehd);
    v.efv = 3'(ef); v.epend = 1'(ep); v.errdy = 1'(er); v.erdat = 3'(erd);
    return v;
  endfunction

  vec_t tbl [22];

  // ---------------- reference model ----------------
  logic [W-1:0] mq[$];
  logic [W-1:0] m_field;
  logic [W-1:0] m_resp_val;
  bit           m_busy;
  bit           m_draining;
  int           m_cyc;
  int           m_resp_cyc;

  function automatic bit m_wrdy();
    return !m_busy && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_rrdy();
    return m_busy && !m_draining && (m_cyc == m_resp_cyc);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_field = RST_V; m_busy = 1'b0; m_draining = 1'b0;
    m_cyc = 0; m_resp_cyc = 0; m_resp_val = '0;
  endtask

  // Advance the model by one clock using the inputs of the current cycle.
  task automatic model_step();
    bit push, pop, old_empty;
    logic [W-1:0] nf;
    push      = wvld && m_wrdy();
    pop       = (mq.size() > 0) && hw_wrdy;
    old_empty = (mq.size() == 0);
    nf = hw_set_vld ? hw_set_dat : (pop ? mq[0] : m_field);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(wdat);
    if (m_busy) begin
      if (m_draining) begin
        if (old_empty) begin
          m_draining = 1'b0;
          m_resp_cyc = m_cyc + RD_LAT + 2;
        end
      end else if (m_cyc == m_resp_cyc) begin
        m_busy = 1'b0;
      end else if (m_cyc == m_resp_cyc - 1) begin
        m_resp_val = (BYP && mq.size() > 0) ? mq[$] : nf;
      end
    end else if (rvld) begin
      m_busy = 1'b1;
      if (BYP || (old_empty && !push)) begin
        m_draining = 1'b0;
        m_resp_cyc = m_cyc + RD_LAT + 2;
      end else begin
        m_draining = 1'b1;
      end
    end
    m_field = nf;
    m_cyc++;
  endtask

  initial begin
    int  k;
    bit  got;
    logic [W-1:0] e_hwd;
    logic         e_rr;

    tbl[0]  = mk(1,5,1,0,0,0, 1,0,0,2,0,0,0);
    tbl[1]  = mk(0,0,1,0,0,0, 1,1,5,2,1,0,0);
    tbl[2]  = mk(0,0,0,0,0,0, 1,0,0,5,0,0,0);
    tbl[3]  = mk(1,1,0,0,0,0, 1,0,0,5,0,0,0);
    tbl[4]  = mk(1,2,0,0,0,0, 1,1,1,5,1,0,0);
    tbl[5]  = mk(1,3,0,0,0,0, 1,1,1,5,1,0,0);
    tbl[6]  = mk(1,4,0,0,0,0, 1,1,1,5,1,0,0);
    tbl[7]  = mk(1,7,0,0,0,0, 0,1,1,5,1,0,0);
    tbl[8]  = mk(0,0,1,0,0,0, 0,1,1,5,1,0,0);
    tbl[9]  = mk(0,0,1,0,0,0, 1,1,2,1,1,0,0);
    tbl[10] = mk(0,0,1,0,0,0, 1,1,3,2,1,0,0);
    tbl[11] = mk(0,0,1,0,0,0, 1,1,4,3,1,0,0);
    tbl[12] = mk(0,0,0,0,0,0, 1,0,0,4,0,0,0);
    tbl[13] = mk(0,0,0,0,0,1, 1,0,0,4,0,0,0);
    tbl[14] = mk(0,0,0,0,0,1, 0,0,0,4,0,0,0);
    tbl[15] = mk(0,0,0,0,0,1, 0,0,0,4,0,0,0);
    tbl[16] = mk(0,0,0,0,0,1, 0,0,0,4,0,0,0);
    tbl[17] = mk(0,0,0,0,0,1, 0,0,0,4,0,1,4);
    tbl[18] = mk(0,0,0,0,0,0, 1,0,0,4,0,0,0);
    tbl[19] = mk(1,2,0,0,0,0, 1,0,0,4,0,0,0);
    tbl[20] = mk(0,0,1,1,6,0, 1,1,2,4,1,0,0);
    tbl[21] = mk(0,0,0,0,0,0, 1,0,0,6,0,0,0);

    // Reset state
    reset_dut();
    #1;
    chk("reset_state", {22'd0, wrdy, hw_wvld, field_val, pending, rrdy, rdat},
        {22'd0, 1'b1, 1'b0, RST_V, 1'b0, 1'b0, 3'd0});

    // Table: each row's expectations are the outputs seen during that cycle
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      wvld = tbl[i].wv; wdat = tbl[i].wd; hw_wrdy = tbl[i].hr;
      hw_set_vld = tbl[i].sv; hw_set_dat = tbl[i].sd; rvld = tbl[i].rv;
      @(negedge clk);
      chk($sformatf("row%0d", i),
          {22'd0, wrdy, hw_wvld, field_val, pending, rrdy, rdat},
          {22'd0, tbl[i].ewrdy, tbl[i].ehwv, tbl[i].efv, tbl[i].epend,
           tbl[i].errdy, tbl[i].erdat});
      if (tbl[i].ehwv) chk($sformatf("row%0d_head", i), {29'd0, hw_wdat}, {29'd0, tbl[i].ehwd});
    end

    // Read behind two pending writes (1, 3) with hardware stalled
    reset_dut();
    hw_wrdy = 1'b0;
    @(posedge clk); #1; wvld = 1'b1; wdat = 3'd1;
    @(posedge clk); #1; wdat = 3'd3;
    @(posedge clk); #1; wvld = 1'b0; rvld = 1'b1;
    k = 0; got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      if (rrdy) begin
        got = 1'b1;
        chk("drain_rdat", {29'd0, rdat}, 32'd3);
        if (BYP) begin
          chk("bypass_latency", k, RD_LAT + 2);
          chk("bypass_pending", {31'd0, pending}, 32'd1);
        end else begin
          chk("drain_latency", k, 11);
          chk("drain_field", {29'd0, field_val}, 32'd3);
        end
        rvld = 1'b0;
      end
      k++;
      if (k == 6) hw_wrdy = 1'b1;
    end
    if (!got) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("resp_one_cycle", {28'd0, rrdy, rdat}, 32'd0);

    // Reset asserted while a read is waiting on the buffer
    reset_dut();
    hw_wrdy = 1'b0;
    @(posedge clk); #1; wvld = 1'b1; wdat = 3'd1;
    @(posedge clk); #1; wdat = 3'd3;
    @(posedge clk); #1; wvld = 1'b0; rvld = 1'b1;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; rvld = 1'b0;
    #1;
    chk("midreset", {25'd0, rrdy, pending, hw_wvld, wrdy, field_val},
        {25'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST_V});
    @(negedge clk); rst_n = 1'b1;

    // Randomized run against the reference model
    reset_dut();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      wvld       = ($urandom_range(0, 1) == 0);
      wdat       = 3'($urandom_range(0, 7));
      hw_wrdy    = ($urandom_range(0, 3) == 0);
      hw_set_vld = ($urandom_range(0, 7) == 0);
      hw_set_dat = 3'($urandom_range(0, 7));
      rvld       = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e_hwd = (mq.size() > 0) ? mq[0] : 3'd0;
      e_rr  = m_rrdy();
      chk($sformatf("rand_c%0d", c),
          {19'd0, wrdy, hw_wvld, (hw_wvld ? hw_wdat : 3'd0), field_val, pending, rrdy, rdat},
          {19'd0, m_wrdy(), (mq.size() > 0), e_hwd, m_field, (mq.size() > 0),
           e_rr, (e_rr ? m_resp_val : 3'd0)});
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
